// File: rtl/frame_pattern_chk.sv
// ---------------------------------------------------------------------------
// frame_pattern_chk
// Receive-side checker for a generated video stream. It tracks frame
// geometry (lines per frame, valid pixels per line), compares every valid
// pixel against the pattern chosen by sel at frame start, and publishes
// per-frame results once the frame closes.
//
// Ports:
//   clk           system clock
//   rst           asynchronous reset, active-high
//   sel[2:0]      pattern select (000 black, 001 white, 011 checkers,
//                 other = geometry only); sampled at frame start
//   fval          frame valid
//   lval          line valid
//   dval          pixel valid, qualified by lval
//   pix_value[7:0] received pixel
//   frame_done    one-cycle pulse when the result outputs update
//   frame_ok      last frame had correct size and zero mismatches
//   size_err      last frame had a bad line length or line count
//   err_count     last frame mismatching pixels (saturating)
//   line_count    last frame lines received
//   last_line_len valid pixels in the last completed line of last frame
// ---------------------------------------------------------------------------
module frame_pattern_chk #(
  parameter int DVAL_HIGH = 640,
  parameter int ROW_COUNT = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic        fval,
  input  logic        lval,
  input  logic        dval,
  input  logic [7:0]  pix_value,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        size_err,
  output logic [15:0] err_count,
  output logic [15:0] line_count,
  output logic [15:0] last_line_len
);

  localparam logic [15:0] LINE_LEN_W = 16'(DVAL_HIGH);
  localparam logic [15:0] ROWS_W     = 16'(ROW_COUNT);
  localparam logic [15:0] CELL_W     = 16'(DVAL_HIGH / 8);
  localparam logic [15:0] CELL_H     = 16'(ROW_COUNT / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    LINE  = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        fval_d_r, lval_d_r;
  logic        fval_low_seen_r;
  logic [2:0]  sel_q_r;
  logic [15:0] x_r, y_r, err_r, last_len_r;
  logic        size_r;
  logic        commit_r;

  logic        fval_rise_s, fval_fall_s, lval_rise_s, lval_fall_s;
  logic        frame_start_s, frame_end_s, line_open_s, line_close_s, pix_s;
  logic [15:0] y_inc_s, y_after_s;
  logic [8:0]  exp_s;
  logic        mismatch_s, size_nxt_s;

  // Returns {compare_enable, expected_pixel} for a pixel at (px, py).
  function automatic logic [8:0] expected_pix(input logic [2:0]  s,
                                              input logic [15:0] px,
                                              input logic [15:0] py);
    logic [15:0] bx;
    logic [15:0] by;
    logic        odd;
    bx = px / CELL_W;
    by = py / CELL_H;
    if (bx > 16'd7) bx = 16'd7;
    if (by > 16'd7) by = 16'd7;
    odd = bx[0] ^ by[0];
    if (px >= LINE_LEN_W) begin
      expected_pix = {1'b0, 8'h00};
    end else begin
      case (s)
        3'b000:  expected_pix = {1'b1, 8'h00};
        3'b001:  expected_pix = {1'b1, 8'hFF};
        3'b011:  expected_pix = {1'b1, (odd ? 8'hFF : 8'h00)};
        default: expected_pix = {1'b0, 8'h00};
      endcase
    end
  endfunction

  // Edge detection and event decoding for the current cycle.
  always_comb begin
    // A rise only counts once fval has been seen low, so a frame already in
    // progress when reset releases is skipped.
    fval_rise_s   = fval & ~fval_d_r & fval_low_seen_r;
    fval_fall_s   = ~fval & fval_d_r;
    lval_rise_s   = lval & ~lval_d_r;
    lval_fall_s   = ~lval & lval_d_r;
    frame_start_s = (state_r == IDLE) & fval_rise_s;
    frame_end_s   = (state_r != IDLE) & fval_fall_s;
    line_open_s   = (state_r == FRAME) & fval & lval_rise_s;
    line_close_s  = (state_r == LINE) & (fval_fall_s | lval_fall_s);
    pix_s         = (state_r == LINE) & fval & lval & dval;
    y_inc_s       = (y_r == 16'hFFFF) ? y_r : (y_r + 16'd1);
    y_after_s     = line_close_s ? y_inc_s : y_r;
    exp_s         = expected_pix(sel_q_r, x_r, y_r);
    mismatch_s    = pix_s & exp_s[8] & (pix_value != exp_s[7:0]);
    size_nxt_s    = size_r
                  | (line_close_s & (x_r != LINE_LEN_W))
                  | (frame_end_s & (y_after_s != ROWS_W));
  end

  // Next-state logic; a frame end takes priority over line events.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (fval_rise_s) state_nxt_s = FRAME;
        else             state_nxt_s = IDLE;
      end
      FRAME: begin
        if (fval_fall_s)      state_nxt_s = IDLE;
        else if (line_open_s) state_nxt_s = LINE;
        else                  state_nxt_s = FRAME;
      end
      LINE: begin
        if (fval_fall_s)      state_nxt_s = IDLE;
        else if (lval_fall_s) state_nxt_s = FRAME;
        else                  state_nxt_s = LINE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and input delay registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      fval_d_r        <= 1'b0;
      lval_d_r        <= 1'b0;
      fval_low_seen_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      fval_d_r <= fval;
      lval_d_r <= lval;
      if (!fval) fval_low_seen_r <= 1'b1;
    end
  end

  // Working accumulators for the frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q_r    <= 3'b000;
      x_r        <= 16'd0;
      y_r        <= 16'd0;
      err_r      <= 16'd0;
      size_r     <= 1'b0;
      last_len_r <= 16'd0;
      commit_r   <= 1'b0;
    end else begin
      commit_r <= frame_end_s;
      if (frame_start_s) begin
        sel_q_r    <= sel;
        x_r        <= 16'd0;
        y_r        <= 16'd0;
        err_r      <= 16'd0;
        size_r     <= 1'b0;
        last_len_r <= 16'd0;
      end else begin
        size_r <= size_nxt_s;
        if (line_open_s) x_r <= 16'd0;
        if (pix_s && (x_r != 16'hFFFF)) x_r <= x_r + 16'd1;
        if (mismatch_s && (err_r != 16'hFFFF)) err_r <= err_r + 16'd1;
        if (line_close_s) begin
          y_r        <= y_inc_s;
          last_len_r <= x_r;
        end
      end
    end
  end

  // Result outputs, loaded one cycle after the frame closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done    <= 1'b0;
      frame_ok      <= 1'b0;
      size_err      <= 1'b0;
      err_count     <= 16'd0;
      line_count    <= 16'd0;
      last_line_len <= 16'd0;
    end else if (commit_r) begin
      frame_done    <= 1'b1;
      frame_ok      <= ~size_r & (err_r == 16'd0);
      size_err      <= size_r;
      err_count     <= err_r;
      line_count    <= y_r;
      last_line_len <= last_len_r;
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule
